// File: rtl/uart_pkg.sv
// Shared UART definitions: frame geometry and receiver state encoding.
// The transmitter imports the same frame constants so both ends agree on 8N1.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    RECEIVE
  } rx_state_t;

  localparam int DATA_BITS  = 8;
  localparam int FRAME_BITS = 10;

endpackage

// File: rtl/uart_rx_sm.sv
// Receiver frame sequencer: tracks IDLE/START/RECEIVE and issues counter clear,
// data shift and byte-ready strobes. Current state is exported for observation.
module uart_rx_sm
  import uart_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       start_det,
  input  logic       sample,
  input  logic [3:0] bit_cnt,
  input  logic       rx_s,
  output logic       clr_cnt,
  output logic       shift,
  output logic       set_rdy,
  output logic [1:0] state
);

  localparam logic [3:0] STOP_IDX = 4'(FRAME_BITS - 1);

  rx_state_t state_q;
  rx_state_t state_d;

  always_comb begin
    state_d = state_q;
    clr_cnt = 1'b0;
    shift   = 1'b0;
    set_rdy = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_det) begin
          clr_cnt = 1'b1;
          state_d = START;
        end
      end
      START: begin
        // A start bit that is high again at its centre was only a glitch.
        if (sample) begin
          state_d = rx_s ? IDLE : RECEIVE;
        end
      end
      RECEIVE: begin
        if (sample) begin
          if (bit_cnt == STOP_IDX) begin
            set_rdy = 1'b1;
            state_d = IDLE;
          end else begin
            shift = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  assign state = state_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: two-flop RX synchronizer, centre-of-bit sampling, and a
// held byte with ready and framing-error flags for the command layer.
module uart_rx
  import uart_pkg::*;
#(
  parameter int BAUD_CNT = 2604
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       RX,
  input  logic       clr_rdy,
  output logic [7:0] rx_data,
  output logic       rdy,
  output logic       frm_err
);

  localparam int CW = $clog2(BAUD_CNT + 1);
  // The detect cycle itself is the first cycle of the half-bit wait, so the
  // first strobe lands BAUD_CNT/2 cycles after it.
  localparam logic [CW-1:0] HALF_LOAD  = CW'(BAUD_CNT / 2 - 1);
  localparam logic [CW-1:0] BIT_RELOAD = CW'(BAUD_CNT - 1);

  logic [1:0]           rx_sync_q, rx_sync_d;
  logic                 rx_prev_q, rx_prev_d;
  logic [CW-1:0]        baud_q, baud_d;
  logic [3:0]           bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
  logic                 rdy_q, rdy_d;
  logic                 frm_err_q, frm_err_d;

  logic       rx_s;
  logic       in_idle;
  logic       start_det;
  logic       sample;
  logic       clr_cnt;
  logic       shift;
  logic       set_rdy;
  logic [1:0] state;

  assign rx_s      = rx_sync_q[1];
  assign in_idle   = (state == IDLE);
  assign start_det = in_idle && rx_prev_q && !rx_s;
  assign sample    = !in_idle && (baud_q == '0);

  uart_rx_sm u_sm (
    .clk       (clk),
    .rst       (rst),
    .start_det (start_det),
    .sample    (sample),
    .bit_cnt   (bit_cnt_q),
    .rx_s      (rx_s),
    .clr_cnt   (clr_cnt),
    .shift     (shift),
    .set_rdy   (set_rdy),
    .state     (state)
  );

  always_comb begin
    rx_sync_d = {rx_sync_q[0], RX};
    rx_prev_d = rx_s;

    baud_d = baud_q;
    if (clr_cnt) begin
      baud_d = HALF_LOAD;
    end else if (sample) begin
      baud_d = BIT_RELOAD;
    end else if (!in_idle) begin
      baud_d = baud_q - 1'b1;
    end

    bit_cnt_d = bit_cnt_q;
    if (clr_cnt) begin
      bit_cnt_d = '0;
    end else if (sample) begin
      bit_cnt_d = bit_cnt_q + 4'd1;
    end

    // LSB arrives first, so after eight right shifts it sits in bit 0.
    shreg_d = shift ? {rx_s, shreg_q[DATA_BITS-1:1]} : shreg_q;

    rx_data_d = rx_data_q;
    frm_err_d = frm_err_q;
    if (set_rdy) begin
      rx_data_d = shreg_q;
      frm_err_d = ~rx_s;
    end

    rdy_d = rdy_q;
    if (set_rdy) begin
      rdy_d = 1'b1;
    end else if (clr_rdy || start_det) begin
      rdy_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_sync_q <= 2'b11;
      rx_prev_q <= 1'b1;
      baud_q    <= '0;
      bit_cnt_q <= '0;
      shreg_q   <= '0;
      rx_data_q <= '0;
      rdy_q     <= 1'b0;
      frm_err_q <= 1'b0;
    end else begin
      rx_sync_q <= rx_sync_d;
      rx_prev_q <= rx_prev_d;
      baud_q    <= baud_d;
      bit_cnt_q <= bit_cnt_d;
      shreg_q   <= shreg_d;
      rx_data_q <= rx_data_d;
      rdy_q     <= rdy_d;
      frm_err_q <= frm_err_d;
    end
  end

  assign rx_data = rx_data_q;
  assign rdy     = rdy_q;
  assign frm_err = frm_err_q;

endmodule
